// File: rtl/gray_frame_ctrl_pkg.sv
// Shared definitions for the grayscale frame capture controller:
// FSM state encodings, RGB444 pixel type, gray weights and small helpers.
package gray_frame_ctrl_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_HOLD    = 2'd3;

   // Weights sum to 16, so a full-scale RGB444 pixel maps to 240 and never overflows 8 bits.
   localparam logic [3:0] W_R = 4'd5;
   localparam logic [3:0] W_G = 4'd9;
   localparam logic [3:0] W_B = 4'd2;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   function automatic logic [7:0] gray_of(input rgb444_t p);
      logic [7:0] pr, pg, pb;
      pr = {4'd0, p.r} * {4'd0, W_R};
      pg = {4'd0, p.g} * {4'd0, W_G};
      pb = {4'd0, p.b} * {4'd0, W_B};
      return pr + pg + pb;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/rgb444_gray_stage.sv
// Registered RGB444 -> 8-bit grayscale converter; valid passes through with
// the same one-cycle latency as the data.
module rgb444_gray_stage
   import gray_frame_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_i,
   input  rgb444_t    pix_i,
   output logic       valid_o,
   output logic [7:0] gray_o
);

   logic       valid_d, valid_q;
   logic [7:0] gray_d, gray_q;

   always_comb begin
      // NOTE: defaults first on every path keep always_comb free of inferred latches.
      valid_d = valid_i;
      gray_d  = gray_q;
      if (valid_i) gray_d = gray_of(pix_i);
   end

   always_ff @(posedge clk) begin
      // NOTE: state flops use nonblocking updates so all registers sample together.
      if (reset) begin
         valid_q <= 1'b0;
         gray_q  <= '0;
      end else begin
         valid_q <= valid_d;
         gray_q  <= gray_d;
      end
   end

   assign valid_o = valid_q;
   assign gray_o  = gray_q;

endmodule

// File: rtl/gray_frame_ctrl.sv
// Camera frame capture into a grayscale frame buffer with publish/ack handshake.
// Define GRAY_FRAME_PINGPONG_EN for double-buffered banks; default is single bank + HOLD.
module gray_frame_ctrl
   import gray_frame_ctrl_pkg::*;
#(
   parameter int H_RES  = 320,
   parameter int V_RES  = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              frame_start,
   input  logic              pix_valid,
   input  logic [3:0]        pix_r,
   input  logic [3:0]        pix_g,
   input  logic [3:0]        pix_b,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              wr_bank,
   output logic              frame_ready,
   output logic              rd_bank,
   input  logic              frame_ack,
   output logic              frame_err,
   output logic [7:0]        drop_cnt
);

   localparam int              NPIX     = H_RES * V_RES;
   localparam logic [ADDR_W:0] LAST_CNT = NPIX[ADDR_W:0];
   localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        state_d, state_q;
   logic [ADDR_W:0]   cnt_d, cnt_q, cnt_base;
   logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
   logic              wr_bank_d, wr_bank_q;
   logic              rd_bank_d, rd_bank_q;
   logic              frame_ready_d, frame_ready_q;
   logic              frame_err_d, frame_err_q;
   logic [7:0]        drop_d, drop_q;
   logic              pix_acc;
   rgb444_t           pix;

   assign pix = '{r: pix_r, g: pix_g, b: pix_b};

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cnt_base      = cnt_q;
      wr_addr_d     = wr_addr_q;
      wr_bank_d     = wr_bank_q;
      rd_bank_d     = rd_bank_q;
      frame_ready_d = frame_ready_q;
      frame_err_d   = 1'b0;
      drop_d        = drop_q;
      pix_acc       = 1'b0;

      // An ack is consumed before any same-cycle publish decision.
      if (frame_ack && frame_ready_q) frame_ready_d = 1'b0;

      case (state_q)
         ST_IDLE: if (enable) state_d = ST_ARMED;
         ST_ARMED: begin
            if (frame_start) begin
               state_d = ST_CAPTURE;
               cnt_d   = '0;
            end
         end
         ST_CAPTURE: begin
            if (cnt_q == LAST_CNT) begin
`ifdef GRAY_FRAME_PINGPONG_EN
               state_d = ST_ARMED;
               if (!frame_ready_d) begin
                  frame_ready_d = 1'b1;
                  rd_bank_d     = wr_bank_q;
                  wr_bank_d     = ~wr_bank_q;
               end else begin
                  drop_d = sat_inc(drop_q);
               end
`else
               state_d       = ST_HOLD;
               frame_ready_d = 1'b1;
`endif
            end else begin
               // A premature frame_start restarts the frame in place, same bank.
               if (frame_start) begin
                  frame_err_d = 1'b1;
                  cnt_base    = '0;
               end
               cnt_d = cnt_base;
               if (pix_valid) begin
                  pix_acc   = 1'b1;
                  wr_addr_d = ADDR_W'(cnt_base);
                  cnt_d     = cnt_base + CNT_ONE;
               end
            end
         end
         ST_HOLD: begin
            if (frame_start) drop_d = sat_inc(drop_q);
            if (frame_ack) state_d = ST_ARMED;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         wr_addr_q     <= '0;
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         frame_ready_q <= 1'b0;
         frame_err_q   <= 1'b0;
         drop_q        <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wr_addr_q     <= wr_addr_d;
         wr_bank_q     <= wr_bank_d;
         rd_bank_q     <= rd_bank_d;
         frame_ready_q <= frame_ready_d;
         frame_err_q   <= frame_err_d;
         drop_q        <= drop_d;
      end
   end

   rgb444_gray_stage u_gray (
      .clk     (clk),
      .reset   (reset),
      .valid_i (pix_acc),
      .pix_i   (pix),
      .valid_o (wr_en),
      .gray_o  (wr_data)
   );

   assign wr_addr     = wr_addr_q;
   assign wr_bank     = wr_bank_q;
   assign rd_bank     = rd_bank_q;
   assign frame_ready = frame_ready_q;
   assign frame_err   = frame_err_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Self-checking bench for gray_frame_ctrl (4x2 frame): behavioural model compared
// every cycle, plus directed literal checks. Follows GRAY_FRAME_PINGPONG_EN if defined.
module tb_gray_frame_ctrl;

   localparam int H = 4, V = 2, NPIX = H * V, AW = 3;

   logic          clk = 1'b0;
   logic          reset, enable, frame_start, pix_valid, frame_ack;
   logic [3:0]    pix_r, pix_g, pix_b;
   logic          wr_en, wr_bank, frame_ready, rd_bank, frame_err;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data, drop_cnt;

   int n_checks = 0;
   int n_errs   = 0;

   always #5 clk = ~clk;

   gray_frame_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .pix_r       (pix_r),
      .pix_g       (pix_g),
      .pix_b       (pix_b),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_bank     (wr_bank),
      .frame_ready (frame_ready),
      .rd_bank     (rd_bank),
      .frame_ack   (frame_ack),
      .frame_err   (frame_err),
      .drop_cnt    (drop_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_ARMED, M_CAP, M_HOLD} mode_t;
   mode_t      m_mode = M_IDLE;
   int         m_pix = 0;
   bit         m_valid = 1'b0;
   logic       e_wr_en, e_ready, e_err, e_wb, e_rb;
   logic [2:0] e_addr;
   logic [7:0] e_data;
   int         e_drop;

   initial forever begin : model
      bit acked;
      @(posedge clk);
      if (reset) begin
         m_mode = M_IDLE; m_pix = 0; m_valid = 1'b1;
         e_wr_en = 0; e_ready = 0; e_err = 0; e_wb = 0; e_rb = 0;
         e_addr = 0; e_data = 0; e_drop = 0;
      end else if (m_valid) begin
         acked   = frame_ack && e_ready;
         e_wr_en = 0;
         e_err   = 0;
         if (acked) e_ready = 0;
         if (m_mode == M_IDLE) begin
            if (enable) m_mode = M_ARMED;
         end else if (m_mode == M_ARMED) begin
            if (frame_start) begin m_mode = M_CAP; m_pix = 0; end
         end else if (m_mode == M_CAP) begin
            if (m_pix == NPIX) begin
`ifdef GRAY_FRAME_PINGPONG_EN
               m_mode = M_ARMED;
               if (e_ready) e_drop = (e_drop < 255) ? e_drop + 1 : 255;
               else begin e_ready = 1; e_rb = e_wb; e_wb = !e_wb; end
`else
               m_mode = M_HOLD;
               e_ready = 1;
`endif
            end else begin
               if (frame_start) begin e_err = 1; m_pix = 0; end
               if (pix_valid) begin
                  e_wr_en = 1;
                  e_addr  = m_pix[2:0];
                  e_data  = 8'(5 * pix_r + 9 * pix_g + 2 * pix_b);
                  m_pix++;
               end
            end
         end else begin
            if (frame_start) e_drop = (e_drop < 255) ? e_drop + 1 : 255;
            if (acked) m_mode = M_ARMED;
         end
      end
   end

   initial forever begin : compare
      @(negedge clk);
      if (m_valid) begin
         check("m_wr_en", wr_en, e_wr_en);
         check("m_frame_ready", frame_ready, e_ready);
         check("m_frame_err", frame_err, e_err);
         check("m_wr_bank", wr_bank, e_wb);
         check("m_rd_bank", rd_bank, e_rb);
         check("m_drop_cnt", drop_cnt, e_drop);
         if (e_wr_en) begin
            check("m_wr_addr", wr_addr, e_addr);
            check("m_wr_data", wr_data, e_data);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic rst, en, fs, pv, input logic [3:0] r, g, b, input logic ack);
      reset = rst; enable = en; frame_start = fs; pix_valid = pv;
      pix_r = r; pix_g = g; pix_b = b; frame_ack = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();   drive(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0); endtask
   task automatic fstart(); drive(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 0); endtask
   task automatic do_ack(); drive(0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1); endtask
   task automatic pixel(input logic [3:0] r, g, b); drive(0, 0, 0, 1, r, g, b, 0); endtask

   // n pixels with idle gaps, addresses starting at first; returns with the last write visible
   task automatic send_pixels(input int first, input int n, input logic bank);
      for (int i = 0; i < n; i++) begin
         if (i % 2 == 1) idle();
         pixel(4'(i + 3), 4'(i), 4'(15 - i));
         check("wr_en_px", wr_en, 1'b1);
         check("wr_addr_px", wr_addr, first + i);
         check("wr_bank_px", wr_bank, bank);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_wr_bank", wr_bank, 0);
      check("rst_rd_bank", rd_bank, 0);
      check("rst_frame_ready", frame_ready, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_drop_cnt", drop_cnt, 0);
   endtask

   initial begin
      drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
      drive(1, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0);
      check_reset_vals();

      drive(0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 0);
      do_ack();
      check("ack_ignored", frame_ready, 0);
      pixel(4'd1, 4'd1, 4'd1);
      check("armed_ignores_px", wr_en, 0);

      // first frame: conversion literals then the rest with gaps
      fstart();
      pixel(4'd15, 4'd15, 4'd15);
      check("gray_white_en", wr_en, 1);
      check("gray_white_addr", wr_addr, 0);
      check("gray_white", wr_data, 240);
      idle();
      check("lat1_drop_en", wr_en, 0);
      pixel(4'd1, 4'd0, 4'd0);
      check("gray_r1_addr", wr_addr, 1);
      check("gray_r1", wr_data, 5);
      pixel(4'd0, 4'd2, 4'd3);
      check("gray_g2b3_addr", wr_addr, 2);
      check("gray_g2b3", wr_data, 24);
      send_pixels(3, 5, 1'b0);
      check("ready_not_yet", frame_ready, 0);
      idle();
      check("ready_after_2", frame_ready, 1);
      check("f1_rd_bank", rd_bank, 0);
`ifdef GRAY_FRAME_PINGPONG_EN
      check("f1_wr_bank", wr_bank, 1);
`else
      check("f1_wr_bank", wr_bank, 0);
`endif
      pixel(4'd2, 4'd2, 4'd2);
      check("post_frame_px_ignored", wr_en, 0);

`ifdef GRAY_FRAME_PINGPONG_EN
      fstart();
      send_pixels(0, 5, 1'b1);
      fstart();
      check("short_err", frame_err, 1);
      send_pixels(0, 8, 1'b1);
      check("short_err_cleared", frame_err, 0);
      idle();
      check("ovr_drop", drop_cnt, 1);
      check("ovr_rd_bank", rd_bank, 0);
      check("ovr_wr_bank", wr_bank, 1);
      check("ovr_ready", frame_ready, 1);
      fstart();
      send_pixels(0, 8, 1'b1);
      do_ack();
      check("ack_pub_ready", frame_ready, 1);
      check("ack_pub_rd_bank", rd_bank, 1);
      check("ack_pub_wr_bank", wr_bank, 0);
      check("ack_pub_drop", drop_cnt, 1);
      do_ack();
      check("ack_clears", frame_ready, 0);
`else
      fstart();
      idle();
      fstart();
      check("hold_drop2", drop_cnt, 2);
      check("hold_ready", frame_ready, 1);
      do_ack();
      check("hold_ack_clears", frame_ready, 0);
      fstart();
      send_pixels(0, 5, 1'b0);
      fstart();
      check("short_err", frame_err, 1);
      send_pixels(0, 8, 1'b0);
      check("short_err_cleared", frame_err, 0);
      idle();
      check("f2_ready", frame_ready, 1);
      check("f2_rd_bank", rd_bank, 0);
      for (int i = 0; i < 260; i++) fstart();
      check("drop_saturates", drop_cnt, 255);
      do_ack();
      check("ack_clears", frame_ready, 0);
`endif

      // reset in the middle of a frame
      fstart();
      send_pixels(0, 3, 1'b0);
      drive(1, 0, 0, 1, 4'd5, 4'd5, 4'd5, 0);
      check_reset_vals();
      drive(0, 0, 1, 0, 4'd0, 4'd0, 4'd0, 0);
      pixel(4'd7, 4'd7, 4'd7);
      check("idle_after_reset", wr_en, 0);
      check("idle_no_err", frame_err, 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
